fetch_seq: RTL and testbench

//  Instruction fetch/sequence unit; reader of program memory (prog.hex ROM).

---
 rtl/num_pkg.sv | 31 +++
 rtl/pc_counter.sv | 22 ++
 rtl/fetch_seq.sv | 112 +++++++++++
 tb/tb_fetch_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/num_pkg.sv
// Shared types for the fetch/sequence unit: opcodes, serial-op selects and FSM states.
package num_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OPC_NOP      = 3'b000,
    OPC_STALL    = 3'b001,
    OPC_MULT_YD  = 3'b010,
    OPC_MULT_X1D = 3'b011,
    OPC_ADD_YX   = 3'b100,
    OPC_RSVD     = 3'b101,
    OPC_WAIT_SW  = 3'b110,
    OPC_LOAD_X   = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    SOP_MULT_YD  = 2'd0,
    SOP_MULT_X1D = 2'd1,
    SOP_ADD_YX   = 2'd2
  } serop_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_BUBBLE,
    ST_EXEC,
    ST_WAITSW
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous active-low clear, increment enable, natural wrap.
module pc_counter #(
  parameter int Psize = 3
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [Psize-1:0] o_count
);

  logic [Psize-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n)
      r_count <= '0;
    else if (i_inc)
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch/sequence unit: reads the program ROM, decodes each opcode and
// drives the bit-serial datapath through a start/done handshake.
//
// state  | meaning
// FETCH  | latch ROM word into ir and advance pc when i_en=1
// DECODE | pick next state; schedule registered start/load pulses
// BUBBLE | single idle cycle for STALL
// EXEC   | serial op running; leave on i_done
// WAITSW | hold while i_sw=1
module fetch_seq
  import num_pkg::*;
#(
  parameter int Psize = 3,
  parameter int Isize = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [Psize-1:0] o_address,
  input  logic [Isize:0]   i_instr,
  input  logic             i_en,
  input  logic             i_sw,
  output logic             o_start,
  output logic [1:0]       o_op,
  input  logic             i_done,
  output logic             o_load,
  output logic             o_busy
);

  fetch_state_t r_state, w_state_nxt;
  logic [Isize:0] r_ir;
  logic           r_start, r_load;
  serop_t         r_op;
  logic           w_inc, w_ir_ld;
  logic           w_start_nxt, w_load_nxt;
  serop_t         w_op_nxt;
  opcode_t        w_opc;

  assign w_opc = opcode_t'(r_ir);

  pc_counter #(.Psize(Psize)) u_pc (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .i_inc   (w_inc),
    .o_count (o_address)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
      r_start <= 1'b0;
      r_load  <= 1'b0;
      r_op    <= SOP_MULT_YD;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_ld)
        r_ir <= i_instr;
      r_start <= w_start_nxt;
      r_load  <= w_load_nxt;
      r_op    <= w_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 1'b0;
    w_ir_ld     = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (i_en) begin
          w_inc       = 1'b1;
          w_ir_ld     = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_opc)
          OPC_STALL:                            w_state_nxt = ST_BUBBLE;
          OPC_MULT_YD, OPC_MULT_X1D, OPC_ADD_YX: w_state_nxt = ST_EXEC;
          OPC_WAIT_SW:                          w_state_nxt = ST_WAITSW;
          default:                              w_state_nxt = ST_FETCH;
        endcase
      end
      ST_BUBBLE: w_state_nxt = ST_FETCH;
      ST_EXEC:   if (i_done) w_state_nxt = ST_FETCH;
      ST_WAITSW: if (!i_sw)  w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // Pulses are computed in DECODE and become visible in the following state.
  always_comb begin
    w_start_nxt = 1'b0;
    w_load_nxt  = 1'b0;
    w_op_nxt    = r_op;
    if (r_state == ST_DECODE) begin
      case (w_opc)
        OPC_MULT_YD:  begin w_start_nxt = 1'b1; w_op_nxt = SOP_MULT_YD;  end
        OPC_MULT_X1D: begin w_start_nxt = 1'b1; w_op_nxt = SOP_MULT_X1D; end
        OPC_ADD_YX:   begin w_start_nxt = 1'b1; w_op_nxt = SOP_ADD_YX;   end
        OPC_LOAD_X:   w_load_nxt = 1'b1;
        default:      ;
      endcase
    end
  end

  assign o_start = r_start;
  assign o_load  = r_load;
  assign o_op    = r_op;
  assign o_busy  = (r_state != ST_FETCH);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq with a combinational ROM model.
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] address;
  logic [2:0] instr;
  logic       en, sw, done;
  logic       start, load, busy;
  logic [1:0] op;
  logic [2:0] rom [8];

  int n_cmp = 0;
  int n_err = 0;

  assign instr = rom[address];

  always #5 clk = ~clk;

  fetch_seq #(.Psize(3), .Isize(2)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .o_address (address),
    .i_instr   (instr),
    .i_en      (en),
    .i_sw      (sw),
    .o_start   (start),
    .o_op      (op),
    .i_done    (done),
    .o_load    (load),
    .o_busy    (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int faddr [9];
  int fcyc  [9];
  int ops   [3];
  int nf, ns, nl, cd, exp_op;
  bit found;

  initial begin
    en = 1'b1; sw = 1'b0; done = 1'b0; rst_n = 1'b0;

    // Full program run with a 16-cycle datapath latency
    rom = '{3'b000, 3'b111, 3'b001, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110};
    do_reset();
    chk("rst_addr",  address, 0);
    chk("rst_busy",  busy,    0);
    chk("rst_start", start,   0);
    chk("rst_load",  load,    0);
    nf = 0; ns = 0; nl = 0; cd = 0; exp_op = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!busy && nf < 9) begin
        faddr[nf] = address;
        fcyc[nf]  = cyc;
        nf++;
      end
      if (load) nl++;
      done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          done = 1'b1;
          chk("op_held", op, exp_op);
        end
      end
      if (start) begin
        if (ns < 3) ops[ns] = op;
        exp_op = op;
        ns++;
        cd = 16;
      end
      if (nf == 9) break;
      tick();
    end
    done = 1'b0;
    chk("fetch_count", nf, 9);
    for (int i = 0; i < 8; i++) chk("fetch_addr", faddr[i], i);
    chk("wrap_addr",  faddr[8], 0);
    chk("cyc_stall",  fcyc[3], 7);
    chk("cyc_mult",   fcyc[4], 26);
    chk("cyc_last",   fcyc[7], 67);
    chk("load_count", nl, 1);
    chk("start_count", ns, 3);
    chk("op0", ops[0], 0);
    chk("op1", ops[1], 1);
    chk("op2", ops[2], 2);

    // WAIT_SW at address 7: pc wraps to 0 and holds while i_sw=1
    rom = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110};
    sw = 1'b1;
    do_reset();
    chk("rst_op", op, 0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy && address == 3'd7) begin found = 1'b1; break; end
      tick();
    end
    chk("reach_pc7", found, 1);
    tick();
    chk("ws_dec_addr", address, 0);
    chk("ws_dec_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ws_addr", address, 0);
      chk("ws_busy", busy, 1);
    end
    sw = 1'b0;
    tick();
    chk("ws_exit_busy", busy, 0);
    chk("ws_exit_addr", address, 0);
    tick();
    chk("ws_next_busy", busy, 1);
    chk("ws_next_addr", address, 1);

    // i_done held high through FETCH/DECODE/BUBBLE of STALL instructions
    rom = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    do_reset();
    done = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("stray_busy",  busy, (k % 3) != 0);
      chk("stray_addr",  address, (k + 2) / 3);
      chk("stray_start", start, 0);
      tick();
    end
    done = 1'b0;

    // Reset during EXEC with pc=4, then a stale i_done
    rom = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    do_reset();
    for (int k = 0; k < 8; k++) tick();
    chk("ex_start", start, 1);
    chk("ex_op",    op, 0);
    chk("ex_addr",  address, 4);
    chk("ex_busy",  busy, 1);
    tick();
    chk("ex_start_pulse", start, 0);
    chk("ex_busy2", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("abort_addr",  address, 0);
    chk("abort_start", start, 0);
    chk("abort_busy",  busy, 0);
    rst_n = 1'b1;
    done  = 1'b1;
    tick();
    done = 1'b0;
    chk("stale_busy", busy, 1);
    chk("stale_addr", address, 1);
    tick();
    chk("stale_fetch", busy, 0);

    // i_en low for 5 cycles at pc=2, then reserved opcode 101 acts as NOP
    rom = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    chk("en_at_pc2", address, 2);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("en_hold_addr", address, 2);
      chk("en_hold_busy", busy, 0);
    end
    en = 1'b1;
    tick();
    chk("en_dec_busy", busy, 1);
    chk("en_dec_addr", address, 3);
    tick();
    chk("rsvd_busy",  busy, 0);
    chk("rsvd_start", start, 0);
    chk("rsvd_load",  load, 0);
    chk("rsvd_addr",  address, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
